// File: rtl/matmul_feeder_pkg.sv
// Shared definitions for the matmul feeder: FSM state encodings and feed-length helper.
package matmul_feeder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Skewed feed length: K products per lane plus the diagonal fill/flush of the array.
  function automatic int unsigned feed_cycles(input int unsigned k, input int unsigned max_dim);
    return k + 2 * (max_dim - 1);
  endfunction

endpackage

// File: rtl/matmul_skew_sel.sv
// Picks the element a skewed lane presents at step t from one captured row (A) or column (B).
module matmul_skew_sel #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int T_W        = 4,
  parameter int DIM_W      = 2
) (
  input  logic [DATA_WIDTH*MAX_DIM-1:0] vec,
  input  logic [T_W-1:0]                t,
  input  logic [DIM_W-1:0]              lane_idx,
  input  logic [DIM_W:0]                k,
  input  logic                          in_bound,
  output logic [DATA_WIDTH-1:0]         elem
);

  logic [T_W:0]       rel;
  logic [DIM_W-1:0]   idx;
  logic               valid;

  // rel wraps negative (msb set) before the lane's diagonal start.
  assign rel   = {1'b0, t} - (T_W+1)'(lane_idx);
  assign idx   = rel[DIM_W-1:0];
  assign valid = in_bound && !rel[T_W] && (rel < (T_W+1)'(k));
  assign elem  = valid ? vec[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: rtl/matmul_feeder.sv
// Skews captured A rows and B columns into a systolic array; optional abort via MATMUL_FEEDER_ABORT_EN.
module matmul_feeder
  import matmul_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W     = $clog2(MAX_DIM)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
`ifdef MATMUL_FEEDER_ABORT_EN
  input  logic                                  abort_i,
`endif
  input  logic                                  start_i,
  input  logic [DIM_W-1:0]                      dim_n_i,
  input  logic [DIM_W-1:0]                      dim_k_i,
  input  logic [DIM_W-1:0]                      dim_m_i,
  input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0] a_mat_i,
  input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0] b_mat_i,
  output logic [DATA_WIDTH*MAX_DIM-1:0]         a_flat_o,
  output logic [DATA_WIDTH*MAX_DIM-1:0]         b_flat_o,
  output logic                                  start_operation_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int T_W    = $clog2(3 * MAX_DIM);
  localparam int LANE_W = DATA_WIDTH * MAX_DIM;
  localparam int MAT_W  = DATA_WIDTH * MAX_DIM * MAX_DIM;

  logic [1:0]         state;
  logic [T_W-1:0]     t, t_next, f_last;
  logic [MAT_W-1:0]   a_cap, b_cap, a_src, b_src;
  logic [DIM_W-1:0]   n_cap, k_cap, m_cap, n_src, k_src, m_src;
  logic [DIM_W:0]     k_cnt;
  logic               start_acc, abort_hit, feed_last, load_next;
  logic [LANE_W-1:0]  a_next, b_next;

  assign start_acc = (state == ST_IDLE) && start_i;

`ifdef MATMUL_FEEDER_ABORT_EN
  assign abort_hit = abort_i && ((state == ST_FEED) || (state == ST_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign f_last    = T_W'(feed_cycles(32'(k_cap) + 1, MAX_DIM) - 1);
  assign feed_last = (state == ST_FEED) && (t == f_last);
  assign load_next = start_acc || ((state == ST_FEED) && !feed_last && !abort_hit);

  // Registered lanes must show step 0 on the first FEED cycle, so the start cycle selects from the live inputs.
  assign t_next = start_acc ? '0 : t + 1'b1;
  assign a_src  = start_acc ? a_mat_i : a_cap;
  assign b_src  = start_acc ? b_mat_i : b_cap;
  assign n_src  = start_acc ? dim_n_i : n_cap;
  assign k_src  = start_acc ? dim_k_i : k_cap;
  assign m_src  = start_acc ? dim_m_i : m_cap;
  assign k_cnt  = {1'b0, k_src} + (DIM_W+1)'(1);

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_a_lane
    matmul_skew_sel #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .T_W(T_W), .DIM_W(DIM_W)) u_sel (
      .vec      (a_src[i*LANE_W +: LANE_W]),
      .t        (t_next),
      .lane_idx (DIM_W'(i)),
      .k        (k_cnt),
      .in_bound (DIM_W'(i) <= n_src),
      .elem     (a_next[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  for (genvar j = 0; j < MAX_DIM; j++) begin : g_b_lane
    logic [LANE_W-1:0] col;
    for (genvar r = 0; r < MAX_DIM; r++) begin : g_col
      assign col[r*DATA_WIDTH +: DATA_WIDTH] = b_src[(r*MAX_DIM+j)*DATA_WIDTH +: DATA_WIDTH];
    end
    matmul_skew_sel #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .T_W(T_W), .DIM_W(DIM_W)) u_sel (
      .vec      (col),
      .t        (t_next),
      .lane_idx (DIM_W'(j)),
      .k        (k_cnt),
      .in_bound (DIM_W'(j) <= m_src),
      .elem     (b_next[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      t        <= '0;
      a_cap    <= '0;
      b_cap    <= '0;
      n_cap    <= '0;
      k_cap    <= '0;
      m_cap    <= '0;
      a_flat_o <= '0;
      b_flat_o <= '0;
    end else begin
      a_flat_o <= load_next ? a_next : '0;
      b_flat_o <= load_next ? b_next : '0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_FEED;
            t     <= '0;
            a_cap <= a_mat_i;
            b_cap <= b_mat_i;
            n_cap <= dim_n_i;
            k_cap <= dim_k_i;
            m_cap <= dim_m_i;
          end
        end
        ST_FEED: begin
          if (abort_hit) begin
            state <= ST_IDLE;
            t     <= '0;
          end else if (feed_last) begin
            state <= ST_DRAIN;
            t     <= '0;
          end else begin
            t <= t_next;
          end
        end
        ST_DRAIN: state <= abort_hit ? ST_IDLE : ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign start_operation_o = (state == ST_FEED) || (state == ST_DRAIN);
  assign busy_o            = (state != ST_IDLE);
  assign done_o            = (state == ST_DONE);

endmodule

// File: tb/tb_matmul_feeder.sv
// Self-checking bench for matmul_feeder: table of jobs, per-cycle scoreboard, reset/abort corner sequences.
module tb_matmul_feeder;

  localparam int DW = 8;
  localparam int MD = 4;
  localparam int LW = DW * MD;
  localparam int MW = DW * MD * MD;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic [1:0]    dim_n_i, dim_k_i, dim_m_i;
  logic [MW-1:0] a_mat_i, b_mat_i;
  logic [LW-1:0] a_flat_o, b_flat_o;
  logic          start_operation_o, busy_o, done_o;
`ifdef MATMUL_FEEDER_ABORT_EN
  logic          abort_i;
`endif

  always #5 clk_i = ~clk_i;

  matmul_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(32)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
`ifdef MATMUL_FEEDER_ABORT_EN
    .abort_i           (abort_i),
`endif
    .start_i           (start_i),
    .dim_n_i           (dim_n_i),
    .dim_k_i           (dim_k_i),
    .dim_m_i           (dim_m_i),
    .a_mat_i           (a_mat_i),
    .b_mat_i           (b_mat_i),
    .a_flat_o          (a_flat_o),
    .b_flat_o          (b_flat_o),
    .start_operation_o (start_operation_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  typedef struct {
    int n;         // dim_n_i value (N-1)
    int k;         // dim_k_i value (K-1)
    int m;         // dim_m_i value (M-1)
    int pat;       // 0: identity A / 1..16 B, else random nonzero
    int exp_done;  // cycle of the done_o pulse, start in cycle 0
    bit extra;     // pulse start_i again at cycles 3 and 12
  } vec_t;

  typedef struct {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          so;
    logic          busy;
    logic          done;
  } exp_t;

  vec_t       vecs[4];
  exp_t       sb[$];
  logic [7:0] am[MD][MD];
  logic [7:0] bm[MD][MD];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fill_mats(input int pat);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        if (pat == 0) begin
          am[r][c] = (r == c) ? 8'd1 : 8'd0;
          bm[r][c] = 8'(r * MD + c + 1);
        end else begin
          am[r][c] = 8'($urandom_range(1, 255));
          bm[r][c] = 8'($urandom_range(1, 255));
        end
      end
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        a_mat_i[(r*MD+c)*DW +: DW] = am[r][c];
        b_mat_i[(r*MD+c)*DW +: DW] = bm[r][c];
      end
  endtask

  function automatic logic [LW-1:0] model_a(input int t, input int n, input int k);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < MD; i++)
      if (t - i >= 0 && t - i < k && i < n) r[i*DW +: DW] = am[i][t-i];
    return r;
  endfunction

  function automatic logic [LW-1:0] model_b(input int t, input int m, input int k);
    logic [LW-1:0] r;
    r = '0;
    for (int j = 0; j < MD; j++)
      if (t - j >= 0 && t - j < k && j < m) r[j*DW +: DW] = bm[t-j][j];
    return r;
  endfunction

  task automatic push_job(input vec_t v);
    exp_t e;
    int f;
    f = (v.k + 1) + 2 * (MD - 1);
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      e = '{a: '0, b: '0, so: 1'b0, busy: 1'b0, done: 1'b0};
      if (c >= 1 && c <= f) begin
        e.a = model_a(c - 1, v.n + 1, v.k + 1);
        e.b = model_b(c - 1, v.m + 1, v.k + 1);
        e.so = 1'b1;
        e.busy = 1'b1;
      end else if (c == f + 1) begin
        e.so = 1'b1;
        e.busy = 1'b1;
      end else if (c == f + 2) begin
        e.busy = 1'b1;
      end
      e.done = (c == v.exp_done);
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    exp_t e;
    int done_cnt;
    logic [LW-1:0] hi_or;
    v = vecs[idx];
    fill_mats(v.pat);
    dim_n_i = 2'(v.n);
    dim_k_i = 2'(v.k);
    dim_m_i = 2'(v.m);
    push_job(v);
    done_cnt = 0;
    hi_or = '0;
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      @(negedge clk_i);
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty j%0d c%0d", idx, c), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("a_flat j%0d c%0d", idx, c), a_flat_o, e.a);
        chk($sformatf("b_flat j%0d c%0d", idx, c), b_flat_o, e.b);
        chk($sformatf("start_op j%0d c%0d", idx, c), 32'(start_operation_o), 32'(e.so));
        chk($sformatf("busy j%0d c%0d", idx, c), 32'(busy_o), 32'(e.busy));
        chk($sformatf("done j%0d c%0d", idx, c), 32'(done_o), 32'(e.done));
      end
      if (done_o) done_cnt++;
      hi_or |= (a_flat_o & 32'hFFFF_0000) | (b_flat_o & 32'hFF00_0000);
      if (idx == 0 && c == 1) chk("a_lane0_t0", 32'(a_flat_o[7:0]), 32'd1);
      if (idx == 0 && c == 3) chk("b_lane3_t2_zero", 32'(b_flat_o[31:24]), 32'd0);
      if (idx == 0 && c == 4) chk("b_lane3_t3", 32'(b_flat_o[31:24]), 32'd4);
      start_i = (c == 0) || (v.extra && (c == 3 || c == 12));
      if (c == 1) begin
        for (int w = 0; w < MW / 32; w++) begin
          a_mat_i[w*32 +: 32] = $urandom;
          b_mat_i[w*32 +: 32] = $urandom;
        end
        dim_n_i = 2'($urandom_range(0, 3));
        dim_k_i = 2'($urandom_range(0, 3));
        dim_m_i = 2'($urandom_range(0, 3));
      end
    end
    start_i = 1'b0;
    chk($sformatf("done_pulses j%0d", idx), 32'(done_cnt), 32'd1);
    if (v.n == 1 && v.m == 2) chk("unused_lanes_zero", hi_or, '0);
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{n: 3, k: 3, m: 3, pat: 0, exp_done: 12, extra: 1'b1};
    vecs[1] = '{n: 3, k: 0, m: 3, pat: 1, exp_done: 9,  extra: 1'b0};
    vecs[2] = '{n: 1, k: 3, m: 2, pat: 1, exp_done: 12, extra: 1'b0};
    vecs[3] = '{n: 0, k: 1, m: 0, pat: 1, exp_done: 10, extra: 1'b0};

    rst_n_i = 1'b0;
    start_i = 1'b0;
    dim_n_i = '0;
    dim_k_i = '0;
    dim_m_i = '0;
    a_mat_i = '0;
    b_mat_i = '0;
`ifdef MATMUL_FEEDER_ABORT_EN
    abort_i = 1'b0;
`endif
    #1;
    chk("rst_a", a_flat_o, '0);
    chk("rst_b", b_flat_o, '0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_so", 32'(start_operation_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) run_job(i);

    // Reset asserted mid-FEED (t=4 during cycle 5).
    fill_mats(0);
    dim_n_i = 2'd3;
    dim_k_i = 2'd3;
    dim_m_i = 2'd3;
    @(negedge clk_i);
    start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_a", a_flat_o, '0);
    chk("async_rst_b", b_flat_o, '0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_so", 32'(start_operation_o), 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dcnt++;
    end
    rst_n_i = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      if (done_o || busy_o) dcnt++;
    end
    chk("no_done_after_rst", 32'(dcnt), 32'd0);
    run_job(1);

`ifdef MATMUL_FEEDER_ABORT_EN
    fill_mats(0);
    dim_n_i = 2'd3;
    dim_k_i = 2'd3;
    dim_m_i = 2'd3;
    @(negedge clk_i);
    start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_so", 32'(start_operation_o), 32'd0);
    chk("abort_a", a_flat_o, '0);
    chk("abort_b", b_flat_o, '0);
    dcnt = 0;
    repeat (14) begin
      @(negedge clk_i);
      if (done_o || start_operation_o) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_job(3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
